// File: rtl/alu_dec_pkg.sv
// Shared types and defaults for the sequenced ALU decoder.
// Holds the FSM state encoding, default field widths, named ALU commands
// and the default per-command flag/multi-cycle masks.
package alu_dec_pkg;

    localparam int CMD_W_DEF  = 3;
    localparam int CTRL_W_DEF = 4;

    // Named ALU command codes (3-bit encoding).
    localparam logic [2:0] CMD_AND = 3'd0;
    localparam logic [2:0] CMD_ORR = 3'd1;
    localparam logic [2:0] CMD_ADD = 3'd2;
    localparam logic [2:0] CMD_SUB = 3'd3;
    localparam logic [2:0] CMD_XOR = 3'd4;
    localparam logic [2:0] CMD_MUL = 3'd5;
    localparam logic [2:0] CMD_LSL = 3'd6;
    localparam logic [2:0] CMD_CMP = 3'd7;

    // Commands whose result updates flag_w[0] (AND, ORR, ADD, SUB, XOR, CMP).
    localparam logic [7:0] FLAG0_MASK_DEF = 8'b1001_1111;
    // Commands that take several cycles in the execute stage (MUL).
    localparam logic [7:0] MC_MASK_DEF    = 8'b0010_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mc_timer.sv
// Loadable down-counter used to stretch multi-cycle ALU commands.
// Loading sets the count to MC_LAT-2; done_o is high when the count is zero.
module alu_mc_timer #(
    parameter int MC_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);

    localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(MC_LAT - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load wins over decrement; the count never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != {CW{1'b0}})) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/alu_decoder_seq.sv
// Registered ALU decoder with valid/ready handshake and multi-cycle sequencing.
// Decodes (alu_op, s, cmd) into an ALU control word and two flag-write
// enables; multi-cycle commands are held back for MC_LAT cycles.
// Optional build macro: ALU_STALL_CNT_EN adds a saturating counter of
// cycles spent waiting on multi-cycle commands (port stall_cnt).
module alu_decoder_seq
    import alu_dec_pkg::*;
#(
    parameter int                      CMD_W      = CMD_W_DEF,
    parameter int                      CTRL_W     = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0]       ADD_CODE   = {CTRL_W{1'b0}},
    parameter logic [(2**CMD_W)-1:0]   FLAG0_MASK = FLAG0_MASK_DEF,
    parameter logic [(2**CMD_W)-1:0]   MC_MASK    = MC_MASK_DEF,
    parameter int                      MC_LAT     = 4
`ifdef ALU_STALL_CNT_EN
    ,
    parameter int                      CNT_W      = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              alu_op,
    input  logic              s,
    input  logic [CMD_W-1:0]  cmd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_control,
    output logic [1:0]        flag_w,
    output logic              mc_busy
`ifdef ALU_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [1:0]        flag_q, flag_d;
    logic              mc_busy_q, mc_busy_d;

    logic              in_ready_s;
    logic              accept_s;
    logic [CTRL_W-1:0] dec_ctrl_s;
    logic [1:0]        dec_flag_s;
    logic              dec_mc_s;
    logic              timer_load_s;
    logic              timer_dec_s;
    logic              timer_done_s;

    // A new request can enter when idle, or when the held result leaves this cycle.
    assign in_ready_s = (state_q == ST_IDLE) ||
                        ((state_q == ST_HOLD) && out_ready);
    assign accept_s   = in_valid && in_ready_s;

    // Combinational decode of the incoming request fields.
    always_comb begin
        if (alu_op) begin
            dec_ctrl_s = CTRL_W'(cmd);
        end else begin
            dec_ctrl_s = ADD_CODE;
        end
        dec_flag_s[1] = s;
        dec_flag_s[0] = alu_op && s && FLAG0_MASK[cmd];
        dec_mc_s      = alu_op && MC_MASK[cmd];
    end

    // FSM next-state and output register updates.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        ctrl_d       = ctrl_q;
        flag_d       = flag_q;
        mc_busy_d    = mc_busy_q;
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept_s) begin
                    // Fresh request (also covers back-to-back from HOLD).
                    ctrl_d = dec_ctrl_s;
                    flag_d = dec_flag_s;
                    if (dec_mc_s) begin
                        state_d      = ST_WAIT;
                        out_valid_d  = 1'b0;
                        mc_busy_d    = 1'b1;
                        timer_load_s = 1'b1;
                    end else begin
                        state_d      = ST_HOLD;
                        out_valid_d  = 1'b1;
                        mc_busy_d    = 1'b0;
                    end
                end else if ((state_q == ST_HOLD) && out_ready) begin
                    // Result consumed with nothing behind it.
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT: begin
                if (timer_done_s) begin
                    state_d     = ST_HOLD;
                    out_valid_d = 1'b1;
                    mc_busy_d   = 1'b0;
                end else begin
                    timer_dec_s = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                mc_busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            ctrl_q      <= {CTRL_W{1'b0}};
            flag_q      <= 2'b00;
            mc_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            flag_q      <= flag_d;
            mc_busy_q   <= mc_busy_d;
        end
    end

    alu_mc_timer #(
        .MC_LAT (MC_LAT)
    ) u_mc_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (timer_load_s),
        .dec_i  (timer_dec_s),
        .done_o (timer_done_s)
    );

`ifdef ALU_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    // Count WAIT cycles, saturating at all-ones.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_WAIT) && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= {CNT_W{1'b0}};
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_q;
    assign alu_control = ctrl_q;
    assign flag_w      = flag_q;
    assign mc_busy     = mc_busy_q;

endmodule

// File: tb/tb_alu_decoder_seq.sv
// Directed self-checking bench for alu_decoder_seq (default parameters).
// Honours ALU_STALL_CNT_EN when defined to also check stall_cnt.
module tb_alu_decoder_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       alu_op;
    logic       s;
    logic [2:0] cmd;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu_control;
    logic [1:0] flag_w;
    logic       mc_busy;
`ifdef ALU_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks;
    int n_fail;

    alu_decoder_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .s           (s),
        .cmd         (cmd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .flag_w      (flag_w),
        .mc_busy     (mc_busy)
`ifdef ALU_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic op, input logic sf, input logic [2:0] c);
        in_valid = v;
        alu_op   = op;
        s        = sf;
        cmd      = c;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0);
        #12;
        n_checks++;
        if ({out_valid, mc_busy, alu_control, flag_w} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b busy=%b ctrl=%h flag=%b, want all zero",
                     out_valid, mc_busy, alu_control, flag_w);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
`ifdef ALU_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 3'b010);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, alu_control, flag_w, mc_busy} !== {1'b1, 4'b0010, 2'b11, 1'b0}) begin
            n_fail++;
            $display("FAIL single_out: got valid=%b ctrl=%b flag=%b busy=%b, want 1 0010 11 0",
                     out_valid, alu_control, flag_w, mc_busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: out_valid got %b want 0", out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flags();
        logic [2:0] v_op  [6];
        logic [2:0] v_cmd [6];
        logic [3:0] e_ctl [6];
        logic [1:0] e_flg [6];
        // {alu_op, s} packed in v_op[1:0]
        v_op[0] = 3'b011; v_cmd[0] = 3'b110; e_ctl[0] = 4'b0110; e_flg[0] = 2'b10;
        v_op[1] = 3'b001; v_cmd[1] = 3'b011; e_ctl[1] = 4'b0000; e_flg[1] = 2'b10;
        v_op[2] = 3'b010; v_cmd[2] = 3'b010; e_ctl[2] = 4'b0010; e_flg[2] = 2'b00;
        v_op[3] = 3'b011; v_cmd[3] = 3'b111; e_ctl[3] = 4'b0111; e_flg[3] = 2'b11;
        v_op[4] = 3'b000; v_cmd[4] = 3'b101; e_ctl[4] = 4'b0000; e_flg[4] = 2'b00;
        v_op[5] = 3'b011; v_cmd[5] = 3'b100; e_ctl[5] = 4'b0100; e_flg[5] = 2'b11;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, v_op[i][1], v_op[i][0], v_cmd[i]);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({out_valid, alu_control, flag_w} !== {1'b1, e_ctl[i], e_flg[i]}) begin
                n_fail++;
                $display("FAIL flags_%0d: got valid=%b ctrl=%b flag=%b, want 1 %b %b",
                         i, out_valid, alu_control, flag_w, e_ctl[i], e_flg[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_multicycle();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 3'b101);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mc_busy, in_ready, out_valid} !== 3'b100) begin
                n_fail++;
                $display("FAIL mc_wait_%0d: got busy=%b in_ready=%b valid=%b, want 1 0 0",
                         i, mc_busy, in_ready, out_valid);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, mc_busy, alu_control, flag_w} !== {1'b1, 1'b0, 4'b0101, 2'b10}) begin
            n_fail++;
            $display("FAIL mc_out: got valid=%b busy=%b ctrl=%b flag=%b, want 1 0 0101 10",
                     out_valid, mc_busy, alu_control, flag_w);
        end
`ifdef ALU_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL mc_stall_cnt: got %0d want 3", stall_cnt);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 3'b001);
        @(posedge clk); #1;
        // A competing request waits while the held result is blocked.
        drive(1'b1, 1'b1, 1'b0, 3'b100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, in_ready, alu_control, flag_w} !== {1'b1, 1'b0, 4'b0001, 2'b11}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got valid=%b in_ready=%b ctrl=%b flag=%b, want 1 0 0001 11",
                         i, out_valid, in_ready, alu_control, flag_w);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, alu_control, flag_w} !== {1'b1, 4'b0100, 2'b00}) begin
            n_fail++;
            $display("FAIL bp_b2b: got valid=%b ctrl=%b flag=%b, want 1 0100 00",
                     out_valid, alu_control, flag_w);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back_mc();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 3'b000);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 3'b101);
        @(negedge clk);
        n_checks++;
        if ({out_valid, alu_control} !== {1'b1, 4'b0000}) begin
            n_fail++;
            $display("FAIL b2b_first: got valid=%b ctrl=%b, want 1 0000", out_valid, alu_control);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, mc_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_drop: got valid=%b busy=%b, want 0 1", out_valid, mc_busy);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, mc_busy, alu_control, flag_w} !== {1'b1, 1'b0, 4'b0101, 2'b00}) begin
            n_fail++;
            $display("FAIL b2b_mc_out: got valid=%b busy=%b ctrl=%b flag=%b, want 1 0 0101 00",
                     out_valid, mc_busy, alu_control, flag_w);
        end
`ifdef ALU_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd6) begin
            n_fail++;
            $display("FAIL b2b_stall_cnt: got %0d want 6", stall_cnt);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_streaming();
        logic [2:0] v_cmd [8];
        logic       v_s   [8];
        logic [1:0] e_flg [8];
        v_cmd[0] = 3'd0; v_s[0] = 1'b1; e_flg[0] = 2'b11;
        v_cmd[1] = 3'd1; v_s[1] = 1'b0; e_flg[1] = 2'b00;
        v_cmd[2] = 3'd2; v_s[2] = 1'b1; e_flg[2] = 2'b11;
        v_cmd[3] = 3'd3; v_s[3] = 1'b1; e_flg[3] = 2'b11;
        v_cmd[4] = 3'd4; v_s[4] = 1'b0; e_flg[4] = 2'b00;
        v_cmd[5] = 3'd6; v_s[5] = 1'b1; e_flg[5] = 2'b10;
        v_cmd[6] = 3'd7; v_s[6] = 1'b1; e_flg[6] = 2'b11;
        v_cmd[7] = 3'd1; v_s[7] = 1'b1; e_flg[7] = 2'b11;
        out_ready = 1'b1;
        drive(1'b1, 1'b1, v_s[0], v_cmd[0]);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k < 7) begin
                drive(1'b1, 1'b1, v_s[k+1], v_cmd[k+1]);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if ({out_valid, in_ready, alu_control, flag_w} !== {1'b1, 1'b1, 1'b0, v_cmd[k], e_flg[k]}) begin
                n_fail++;
                $display("FAIL stream_%0d: got valid=%b in_ready=%b ctrl=%b flag=%b, want 1 1 0%b %b",
                         k, out_valid, in_ready, alu_control, flag_w, v_cmd[k], e_flg[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 3'b101);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, mc_busy, alu_control, flag_w} !== 8'b0) begin
            n_fail++;
            $display("FAIL rst_wait_async: got valid=%b busy=%b ctrl=%b flag=%b, want all zero",
                     out_valid, mc_busy, alu_control, flag_w);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, mc_busy, in_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL rst_wait_after_%0d: got valid=%b busy=%b in_ready=%b, want 0 0 1",
                         i, out_valid, mc_busy, in_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_flags();
        test_multicycle();
        test_backpressure();
        test_back_to_back_mc();
        test_streaming();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
